// File: rtl/alu_issue_stage_if.sv
// Decoded-op input, external ALU connection and result output of alu_issue_stage.
// master = surrounding environment (decoder, ALU, writeback); slave = the issue stage.
interface alu_issue_stage_if #(
  parameter int RD_W = 5,
  parameter int OP_W = 4
);
  logic            in_valid;
  logic            in_ready;
  logic [OP_W-1:0] in_op;
  logic [RD_W-1:0] in_rs1;
  logic [RD_W-1:0] in_rs2;
  logic [RD_W-1:0] in_rd;
  logic [31:0]     in_rs1_val;
  logic [31:0]     in_rs2_val;
  logic            in_use_imm;
  logic [31:0]     in_imm;
  logic [31:0]     alu_a;
  logic [31:0]     alu_b;
  logic [OP_W-1:0] alu_sel;
  logic [31:0]     alu_y;
  logic            alu_zero;
  logic            alu_carry;
  logic            alu_overflow;
  logic            out_valid;
  logic            out_ready;
  logic [RD_W-1:0] out_rd;
  logic [31:0]     out_y;
  logic [2:0]      out_flags;

  modport master (
    output in_valid, in_op, in_rs1, in_rs2, in_rd, in_rs1_val, in_rs2_val, in_use_imm, in_imm,
    input  in_ready,
    input  alu_a, alu_b, alu_sel,
    output alu_y, alu_zero, alu_carry, alu_overflow,
    input  out_valid, out_rd, out_y, out_flags,
    output out_ready
  );

  modport slave (
    input  in_valid, in_op, in_rs1, in_rs2, in_rd, in_rs1_val, in_rs2_val, in_use_imm, in_imm,
    output in_ready,
    output alu_a, alu_b, alu_sel,
    input  alu_y, alu_zero, alu_carry, alu_overflow,
    output out_valid, out_rd, out_y, out_flags,
    input  out_ready
  );
endinterface

// File: rtl/alu_issue_stage.sv
// Two-stage operand-issue / result-capture pipeline in front of an external combinational ALU.
// Define ALU_ISSUE_PERF_EN to add the perf_issued / perf_stall counters.
module alu_issue_stage #(
  parameter int RD_W = 5,
  parameter int OP_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  alu_issue_stage_if.slave   bus
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [31:0]        perf_issued,
  output logic [31:0]        perf_stall
`endif
);

  logic            s1_valid_q, s1_valid_d;
  logic [OP_W-1:0] s1_op_q, s1_op_d;
  logic [RD_W-1:0] s1_rs1_q, s1_rs1_d;
  logic [RD_W-1:0] s1_rs2_q, s1_rs2_d;
  logic [RD_W-1:0] s1_rd_q, s1_rd_d;
  logic            s1_use_imm_q, s1_use_imm_d;
  logic [31:0]     s1_a_q, s1_a_d;
  logic [31:0]     s1_b_q, s1_b_d;
  logic [31:0]     alu_a_q, alu_a_d;
  logic [31:0]     alu_b_q, alu_b_d;
  logic            s2_valid_q, s2_valid_d;
  logic [RD_W-1:0] s2_rd_q, s2_rd_d;
  logic [31:0]     s2_y_q, s2_y_d;
  logic [2:0]      s2_flags_q, s2_flags_d;

  logic            s2_free, retire, advance, in_ready, s1_load;
  logic            fwd_a, fwd_b;
  logic [31:0]     drive_a, drive_b;

  // Register 0 is hard-zero, so it never matches a producer.
  function automatic logic hit(input logic [RD_W-1:0] dst, input logic [RD_W-1:0] src);
    return (dst == src) && (src != '0);
  endfunction

  always_comb begin
    s2_free  = !s2_valid_q || bus.out_ready;
    retire   = s2_valid_q && bus.out_ready;
    advance  = s1_valid_q && s2_free;
    in_ready = !s1_valid_q || s2_free;
    s1_load  = bus.in_valid && in_ready;
    fwd_a    = s2_valid_q && hit(s2_rd_q, s1_rs1_q);
    fwd_b    = s2_valid_q && !s1_use_imm_q && hit(s2_rd_q, s1_rs2_q);
    drive_a  = fwd_a ? s2_y_q : s1_a_q;
    drive_b  = fwd_b ? s2_y_q : s1_b_q;
  end

  always_comb begin
    s1_valid_d   = s1_load || (s1_valid_q && !advance);
    s1_op_d      = s1_op_q;
    s1_rs1_d     = s1_rs1_q;
    s1_rs2_d     = s1_rs2_q;
    s1_rd_d      = s1_rd_q;
    s1_use_imm_d = s1_use_imm_q;
    s1_a_d       = s1_a_q;
    s1_b_d       = s1_b_q;
    if (s1_load) begin
      s1_op_d      = bus.in_op;
      s1_rs1_d     = bus.in_rs1;
      s1_rs2_d     = bus.in_rs2;
      s1_rd_d      = bus.in_rd;
      s1_use_imm_d = bus.in_use_imm;
      // A producer leaving S2 this cycle is not yet visible in the register-file read.
      s1_a_d = (retire && hit(s2_rd_q, bus.in_rs1)) ? s2_y_q : bus.in_rs1_val;
      if (bus.in_use_imm)
        s1_b_d = bus.in_imm;
      else
        s1_b_d = (retire && hit(s2_rd_q, bus.in_rs2)) ? s2_y_q : bus.in_rs2_val;
    end else if (s1_valid_q && !advance && retire) begin
      if (hit(s2_rd_q, s1_rs1_q))
        s1_a_d = s2_y_q;
      if (!s1_use_imm_q && hit(s2_rd_q, s1_rs2_q))
        s1_b_d = s2_y_q;
    end
    // Remember the last operands driven so the ALU inputs stay put while S1 is empty.
    alu_a_d = s1_valid_q ? drive_a : alu_a_q;
    alu_b_d = s1_valid_q ? drive_b : alu_b_q;
  end

  always_comb begin
    s2_valid_d = advance || (s2_valid_q && !bus.out_ready);
    s2_rd_d    = s2_rd_q;
    s2_y_d     = s2_y_q;
    s2_flags_d = s2_flags_q;
    if (advance) begin
      s2_rd_d    = s1_rd_q;
      s2_y_d     = bus.alu_y;
      s2_flags_d = {bus.alu_overflow, bus.alu_carry, bus.alu_zero};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_op_q      <= '0;
      s1_rs1_q     <= '0;
      s1_rs2_q     <= '0;
      s1_rd_q      <= '0;
      s1_use_imm_q <= 1'b0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      s2_valid_q   <= 1'b0;
      s2_rd_q      <= '0;
      s2_y_q       <= '0;
      s2_flags_q   <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_op_q      <= s1_op_d;
      s1_rs1_q     <= s1_rs1_d;
      s1_rs2_q     <= s1_rs2_d;
      s1_rd_q      <= s1_rd_d;
      s1_use_imm_q <= s1_use_imm_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      s2_valid_q   <= s2_valid_d;
      s2_rd_q      <= s2_rd_d;
      s2_y_q       <= s2_y_d;
      s2_flags_q   <= s2_flags_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.alu_a     = alu_a_d;
  assign bus.alu_b     = alu_b_d;
  assign bus.alu_sel   = s1_op_q;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_rd    = s2_rd_q;
  assign bus.out_y     = s2_y_q;
  assign bus.out_flags = s2_flags_q;

`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] perf_issued_q, perf_issued_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_issued_d = perf_issued_q + (advance ? 32'd1 : 32'd0);
    perf_stall_d  = perf_stall_q + ((bus.in_valid && !in_ready) ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issued_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      perf_issued_q <= perf_issued_d;
      perf_stall_q  <= perf_stall_d;
    end
  end

  assign perf_issued = perf_issued_q;
  assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: in-order architectural model plus queue scoreboard.
module tb_alu_issue_stage;
  localparam int RD_W = 5;
  localparam int OP_W = 4;
  localparam logic [3:0] OP_ADD = 4'd3;
  localparam logic [3:0] OP_SUB = 4'd4;
  localparam logic [3:0] OP_SLL = 4'd8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_issue_stage_if #(.RD_W(RD_W), .OP_W(OP_W)) bus ();

`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] perf_issued, perf_stall;
  alu_issue_stage #(.RD_W(RD_W), .OP_W(OP_W)) dut (
    .clk(clk), .rst(rst), .bus(bus), .perf_issued(perf_issued), .perf_stall(perf_stall)
  );
`else
  alu_issue_stage #(.RD_W(RD_W), .OP_W(OP_W)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
`endif

  // Reference ALU: returns {overflow, carry, zero, y}.
  function automatic logic [34:0] alu_calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] y;
    logic c, v;
    s = '0; y = '0; c = 1'b0; v = 1'b0;
    case (op)
      4'd0: y = a & b;
      4'd1: y = a | b;
      4'd2: y = a ^ b;
      4'd3: begin s = {1'b0, a} + {1'b0, b}; y = s[31:0]; c = s[32]; v = (a[31] == b[31]) && (y[31] != a[31]); end
      4'd4: begin s = {1'b0, a} + {1'b0, ~b} + 33'd1; y = s[31:0]; c = s[32]; v = (a[31] != b[31]) && (y[31] != a[31]); end
      4'd5: y = ~(a & b);
      4'd6: y = ~(a | b);
      4'd7: y = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd8: y = a << b[4:0];
      4'd9: y = a >> b[4:0];
      default: y = 32'd0;
    endcase
    return {v, c, (y == 32'd0), y};
  endfunction

  assign {bus.alu_overflow, bus.alu_carry, bus.alu_zero, bus.alu_y} = alu_calc(bus.alu_sel, bus.alu_a, bus.alu_b);

  typedef struct packed {
    logic [RD_W-1:0] rd;
    logic [31:0]     y;
    logic [2:0]      flags;
    logic [31:0]     stamp;
    logic            seen;
  } exp_t;

  exp_t        q[$];
  logic [31:0] gold_rf[32];
  logic [31:0] commit_rf[32];
  logic [31:0] cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_retired = 0;
  logic [31:0] perf_issued_exp = 0;
  logic [31:0] perf_stall_exp = 0;
  logic        prev_hold = 1'b0;
  logic [RD_W-1:0] prev_rd;
  logic [31:0] prev_y;
  logic [2:0]  prev_flags;
  logic        last_ov, last_in_ready, last_acc;
  logic [RD_W-1:0] last_rd;
  logic [31:0] last_y;
  logic [2:0]  last_flags;

  task automatic set_rf(input int idx, input logic [31:0] val);
    commit_rf[idx] = val;
    gold_rf[idx]   = val;
  endtask

  task automatic drive_op(input logic [3:0] op, input int rs1, input int rs2, input int rd,
                          input logic use_imm, input logic [31:0] imm);
    bus.in_valid   = 1'b1;
    bus.in_op      = op;
    bus.in_rs1     = RD_W'(rs1);
    bus.in_rs2     = RD_W'(rs2);
    bus.in_rd      = RD_W'(rd);
    bus.in_use_imm = use_imm;
    bus.in_imm     = imm;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  // One clock: refresh register-file reads, observe at negedge, update model, advance.
  task automatic step();
    exp_t e;
    logic [31:0] a, b;
    logic [34:0] r;
    logic exp_ready, exp_ov;
    bus.in_rs1_val = commit_rf[bus.in_rs1];
    bus.in_rs2_val = commit_rf[bus.in_rs2];
    @(negedge clk);
    last_ov = bus.out_valid; last_in_ready = bus.in_ready; last_acc = 1'b0;
    last_rd = bus.out_rd; last_y = bus.out_y; last_flags = bus.out_flags;
    if (q.size() > 0 && (cyc - q[0].stamp) > 32'd1 && !q[0].seen) begin
      e = q[0]; e.seen = 1'b1; q[0] = e;
      perf_issued_exp++;
    end
    if (rst) begin
      q.delete();
      gold_rf = commit_rf;
      prev_hold = 1'b0;
      perf_issued_exp = 0;
      perf_stall_exp = 0;
    end else begin
      exp_ready = !(q.size() == 2 && !bus.out_ready);
      exp_ov    = (q.size() > 0) && ((cyc - q[0].stamp) > 32'd1);
      n_checks++;
      if (bus.in_ready !== exp_ready) begin
        n_fail++; $display("FAIL in_ready cyc=%0d: got %b expected %b", cyc, bus.in_ready, exp_ready);
      end
      n_checks++;
      if (bus.out_valid !== exp_ov) begin
        n_fail++; $display("FAIL out_valid cyc=%0d: got %b expected %b", cyc, bus.out_valid, exp_ov);
      end
      if (prev_hold) begin
        n_checks++;
        if ({bus.out_rd, bus.out_y, bus.out_flags} !== {prev_rd, prev_y, prev_flags}) begin
          n_fail++; $display("FAIL hold_stable cyc=%0d: got rd=%0d y=%h f=%b expected rd=%0d y=%h f=%b",
                             cyc, bus.out_rd, bus.out_y, bus.out_flags, prev_rd, prev_y, prev_flags);
        end
      end
      if (exp_ov && bus.out_ready) begin
        e = q.pop_front();
        n_retired++;
        n_checks++;
        if (bus.out_rd !== e.rd || bus.out_y !== e.y || bus.out_flags !== e.flags) begin
          n_fail++; $display("FAIL result cyc=%0d: got rd=%0d y=%h f=%b expected rd=%0d y=%h f=%b",
                             cyc, bus.out_rd, bus.out_y, bus.out_flags, e.rd, e.y, e.flags);
        end
        if (e.rd != '0) commit_rf[e.rd] = e.y;
      end
      if (bus.in_valid && exp_ready) begin
        last_acc = 1'b1;
        a = gold_rf[bus.in_rs1];
        b = bus.in_use_imm ? bus.in_imm : gold_rf[bus.in_rs2];
        r = alu_calc(bus.in_op, a, b);
        e.rd = bus.in_rd; e.y = r[31:0]; e.flags = r[34:32]; e.stamp = cyc; e.seen = 1'b0;
        q.push_back(e);
        if (bus.in_rd != '0) gold_rf[bus.in_rd] = r[31:0];
      end
      if (bus.in_valid && !exp_ready) perf_stall_exp++;
      prev_hold = exp_ov && !bus.out_ready;
      prev_rd = bus.out_rd; prev_y = bus.out_y; prev_flags = bus.out_flags;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    int k;
    k = 0;
    idle();
    bus.out_ready = 1'b1;
    while (q.size() > 0 && k < 20) begin step(); k++; end
    step();
    n_checks++;
    if (q.size() != 0) begin
      n_fail++; $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic test_reset();
    int ret0;
    rst = 1'b1; idle(); bus.out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    set_rf(6, 32'h0000_0100);
    drive_op(OP_ADD, 6, 0, 2, 1'b1, 32'h1); step();
    drive_op(OP_ADD, 2, 0, 3, 1'b1, 32'h2); step();
    idle(); step();
    rst = 1'b1; step();
    n_checks++;
    if (last_ov !== 1'b1) begin n_fail++; $display("FAIL pre_reset_valid: got %b expected 1", last_ov); end
    step();
    n_checks++;
    if (last_ov !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", last_ov); end
    rst = 1'b0; ret0 = n_retired; bus.out_ready = 1'b1;
    step();
    n_checks++;
    if (last_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", last_in_ready); end
    n_checks++;
    if ({last_y, last_rd, last_flags} !== '0) begin
      n_fail++; $display("FAIL reset_out_regs: got y=%h rd=%0d f=%b expected 0", last_y, last_rd, last_flags);
    end
    n_checks++;
    if ({bus.alu_a, bus.alu_b, bus.alu_sel} !== '0) begin
      n_fail++; $display("FAIL reset_alu_drive: got a=%h b=%h sel=%0d expected 0", bus.alu_a, bus.alu_b, bus.alu_sel);
    end
    step(); step();
    n_checks++;
    if (n_retired != ret0 || last_ov !== 1'b0) begin
      n_fail++; $display("FAIL reset_no_handshake: got %0d retired valid=%b expected 0", n_retired - ret0, last_ov);
    end
  endtask

  task automatic test_add();
    bus.out_ready = 1'b1;
    set_rf(1, 32'd5); set_rf(2, 32'd7);
    drive_op(OP_ADD, 1, 2, 3, 1'b0, 32'h0); step();
    idle(); step();
    n_checks++;
    if (last_ov !== 1'b0) begin n_fail++; $display("FAIL add_latency_early: got %b expected 0", last_ov); end
    step();
    n_checks++;
    if ({last_ov, last_rd, last_y, last_flags} !== {1'b1, 5'd3, 32'd12, 3'b000}) begin
      n_fail++; $display("FAIL add_result: got v=%b rd=%0d y=%h f=%b expected v=1 rd=3 y=0000000c f=000",
                         last_ov, last_rd, last_y, last_flags);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    set_rf(5, 32'hFFFF_FFFF); set_rf(1, 32'h0000_1234);
    drive_op(OP_ADD, 5, 0, 1, 1'b1, 32'h1); step();
    drive_op(OP_SUB, 1, 0, 2, 1'b1, 32'h1); step();
    idle(); step();
    n_checks++;
    if ({last_rd, last_y, last_flags} !== {5'd1, 32'h0, 3'b011}) begin
      n_fail++; $display("FAIL b2b_add: got rd=%0d y=%h f=%b expected rd=1 y=00000000 f=011", last_rd, last_y, last_flags);
    end
    step();
    n_checks++;
    if ({last_rd, last_y, last_flags} !== {5'd2, 32'hFFFF_FFFF, 3'b000}) begin
      n_fail++; $display("FAIL b2b_sub_fwd: got rd=%0d y=%h f=%b expected rd=2 y=ffffffff f=000", last_rd, last_y, last_flags);
    end
    drain();
  endtask

  task automatic test_stall();
    int ret0;
    ret0 = n_retired;
    bus.out_ready = 1'b0;
    drive_op(OP_ADD, 0, 0, 1, 1'b1, 32'h11); step();
    drive_op(OP_ADD, 0, 0, 2, 1'b1, 32'h22); step();
    drive_op(OP_ADD, 1, 2, 3, 1'b0, 32'h0);  step();
    n_checks++;
    if (last_in_ready !== 1'b0 || last_acc !== 1'b0) begin
      n_fail++; $display("FAIL stall_in_ready: got %b expected 0", last_in_ready);
    end
    step();
    n_checks++;
    if (last_in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready2: got %b expected 0", last_in_ready); end
    bus.out_ready = 1'b1; step();
    n_checks++;
    if (last_acc !== 1'b1) begin n_fail++; $display("FAIL stall_accept: got %b expected 1", last_acc); end
    drain();
    n_checks++;
    if (n_retired - ret0 != 3) begin n_fail++; $display("FAIL stall_count: got %0d expected 3", n_retired - ret0); end
  endtask

  task automatic test_hold_refresh();
    set_rf(4, 32'hDEAD_0000);
    bus.out_ready = 1'b0;
    drive_op(OP_ADD, 0, 0, 4, 1'b1, 32'h10); step();
    drive_op(OP_SLL, 4, 0, 6, 1'b1, 32'h2);  step();
    idle(); step(); step();
    bus.out_ready = 1'b1; step();
    n_checks++;
    if ({last_rd, last_y} !== {5'd4, 32'h10}) begin
      n_fail++; $display("FAIL hold_producer: got rd=%0d y=%h expected rd=4 y=00000010", last_rd, last_y);
    end
    bus.out_ready = 1'b0; step();
    n_checks++;
    if ({last_ov, last_rd, last_y} !== {1'b1, 5'd6, 32'h40}) begin
      n_fail++; $display("FAIL hold_sll: got v=%b rd=%0d y=%h expected v=1 rd=6 y=00000040", last_ov, last_rd, last_y);
    end
    drain();
  endtask

  task automatic test_rd_zero();
    bus.out_ready = 1'b1;
    drive_op(OP_ADD, 0, 0, 0, 1'b1, 32'h5); step();
    drive_op(OP_ADD, 0, 0, 7, 1'b1, 32'h0); step();
    idle(); step();
    n_checks++;
    if ({last_rd, last_y} !== {5'd0, 32'h5}) begin
      n_fail++; $display("FAIL rd0_producer: got rd=%0d y=%h expected rd=0 y=00000005", last_rd, last_y);
    end
    step();
    n_checks++;
    if ({last_rd, last_y, last_flags} !== {5'd7, 32'h0, 3'b001}) begin
      n_fail++; $display("FAIL rd0_consumer: got rd=%0d y=%h f=%b expected rd=7 y=00000000 f=001", last_rd, last_y, last_flags);
    end
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(3, 0) != 0)
        drive_op(4'($urandom_range(10, 0)), int'($urandom_range(3, 0)), int'($urandom_range(3, 0)),
                 int'($urandom_range(3, 0)), ($urandom_range(3, 0) == 0),
                 ($urandom_range(1, 0) == 0) ? 32'($urandom_range(31, 0)) : $urandom);
      else
        idle();
      bus.out_ready = ($urandom_range(3, 0) != 0);
      step();
    end
    drain();
  endtask

  task automatic test_perf();
`ifdef ALU_ISSUE_PERF_EN
    n_checks++;
    if (perf_issued !== perf_issued_exp) begin
      n_fail++; $display("FAIL perf_issued: got %0d expected %0d", perf_issued, perf_issued_exp);
    end
    n_checks++;
    if (perf_stall !== perf_stall_exp) begin
      n_fail++; $display("FAIL perf_stall: got %0d expected %0d", perf_stall, perf_stall_exp);
    end
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      commit_rf[i] = (i == 0) ? 32'h0 : $urandom;
      gold_rf[i]   = commit_rf[i];
    end
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_op = '0; bus.in_rs1 = '0; bus.in_rs2 = '0; bus.in_rd = '0;
    bus.in_rs1_val = '0; bus.in_rs2_val = '0; bus.in_use_imm = 1'b0; bus.in_imm = '0;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_add();
    test_back_to_back();
    test_stall();
    test_hold_refresh();
    test_rd_zero();
    test_random();
    test_perf();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
